alu_seq: RTL

- Registered, multi-cycle successor to the team's combinational datapath ALU. Width is parametrised and it uses a START/BUSY/DONE handshake.
- Adds rotate and arithmetic-shift operations, executed bit-serially (one bit position per cycle), and a real signed-overflow flag.
- Sits between the register file and the writeback stage of the processor datapath. The controller issues one operation at a time.

---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// alu_seq handshake and operand/result bus.
// master = issuing controller, slave = alu_seq.
interface alu_seq_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int SHAMT_WIDTH = 4
);
  logic                   start;
  logic [DATA_WIDTH-1:0]  a;
  logic [DATA_WIDTH-1:0]  b;
  logic [SHAMT_WIDTH-1:0] x;
  logic [3:0]             opcode;
  logic                   busy;
  logic                   done;
  logic [DATA_WIDTH-1:0]  alu_out;
  logic [7:0]             flags_out;

  modport master (
    output start, a, b, x, opcode,
    input  busy, done, alu_out, flags_out
  );

  modport slave (
    input  start, a, b, x, opcode,
    output busy, done, alu_out, flags_out
  );
endinterface

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with bit-serial shifts/rotates.
// START/BUSY/DONE handshake, signed status flags.
module alu_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int SHAMT_WIDTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic [3:0] OP_SRA = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_INC = 4'b1000;
  localparam logic [3:0] OP_DEC = 4'b1001;
  localparam logic [3:0] OP_ADD = 4'b1010;
  localparam logic [3:0] OP_SUB = 4'b1011;
  localparam logic [3:0] OP_SHL = 4'b1100;
  localparam logic [3:0] OP_SHR = 4'b1101;
  localparam logic [3:0] OP_ROL = 4'b1110;
  localparam logic [3:0] OP_ROR = 4'b1111;

  logic [1:0]             state;
  logic [3:0]             op_q;
  logic [MSB:0]           a_q;
  logic [MSB:0]           b_q;
  logic [MSB:0]           work;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic                   busy_q;
  logic                   done_q;
  logic [MSB:0]           out_q;
  logic [7:0]             flags_q;

  logic                   in_shift;
  logic [MSB:0]           step;
  logic [MSB:0]           res;
  logic [MSB:0]           sum;
  logic                   ov;
  logic [7:0]             flags_d;

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.alu_out   = out_q;
  assign bus.flags_out = flags_q;

  // Ops that run through the serial work register.
  assign in_shift = (bus.opcode[3:2] == 2'b11) ||
                    (bus.opcode == OP_SRA);

  // One-bit step applied to the work register per SHIFT cycle.
  always_comb begin
    step = work;
    case (op_q)
      OP_SHL:  step = {work[MSB-1:0], 1'b0};
      OP_SHR:  step = {1'b0, work[MSB:1]};
      OP_ROL:  step = {work[MSB-1:0], work[MSB]};
      OP_ROR:  step = {work[0], work[MSB:1]};
      OP_SRA:  step = {work[MSB], work[MSB:1]};
      default: step = work;
    endcase
  end

  // Final result and signed overflow from the latched operands.
  always_comb begin
    res = a_q;
    sum = '0;
    ov  = 1'b0;
    case (op_q)
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_NOT: res = ~a_q;
      OP_INC: begin
        sum = a_q + DATA_WIDTH'(1);
        res = sum;
        ov  = !a_q[MSB] && sum[MSB];
      end
      OP_DEC: begin
        sum = a_q - DATA_WIDTH'(1);
        res = sum;
        ov  = a_q[MSB] && !sum[MSB];
      end
      OP_ADD: begin
        sum = a_q + b_q;
        res = sum;
        ov  = (a_q[MSB] == b_q[MSB]) &&
              (sum[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        sum = a_q - b_q;
        res = sum;
        ov  = (a_q[MSB] != b_q[MSB]) &&
              (sum[MSB] != a_q[MSB]);
      end
      OP_SHL, OP_SHR,
      OP_ROL, OP_ROR,
      OP_SRA: res = work;
      default: res = a_q;
    endcase
  end

  // Status flags on the signed result.
  always_comb begin
    flags_d    = 8'h00;
    flags_d[0] = (res == '0);
    flags_d[1] = (res != '0);
    flags_d[2] = (res == DATA_WIDTH'(1));
    flags_d[3] = res[MSB];
    flags_d[4] = !res[MSB] && (res != '0);
    flags_d[5] = res[MSB] || (res == '0);
    flags_d[6] = !res[MSB];
    flags_d[7] = ov;
  end

  // Control FSM; BUSY covers the DONE cycle, so the next
  // accept happens the cycle after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work    <= '0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      flags_q <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (bus.start) begin
            op_q   <= bus.opcode;
            a_q    <= bus.a;
            b_q    <= bus.b;
            work   <= bus.a;
            cnt    <= bus.x;
            busy_q <= 1'b1;
            if (in_shift && (bus.x != '0))
              state <= SHIFT;
            else
              state <= FINISH;
          end
        end
        SHIFT: begin
          work <= step;
          cnt  <= cnt - SHAMT_WIDTH'(1);
          if (cnt == SHAMT_WIDTH'(1))
            state <= FINISH;
        end
        FINISH: begin
          out_q   <= res;
          flags_q <= flags_d;
          done_q  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
